// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of resolved stores that tracks commit status,
// drains committed stores to memory in order and forwards the youngest match to loads.
package common_pkg;
  localparam int WORD_SIZE_P = 32;
endpackage

module store_buffer
  import common_pkg::*;
#(
  parameter int SB_ENTRY = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   exe_sb_valid_i,
  input  logic [WORD_SIZE_P-1:0] exe_sb_addr_i,
  input  logic [WORD_SIZE_P-1:0] exe_sb_data_i,
  output logic                   sb_exe_ready_o,
  input  logic                   rob_sb_valid_i,
  input  logic                   rob_mispredict_i,
  output logic                   sb_mem_valid_o,
  output logic [WORD_SIZE_P-1:0] sb_mem_addr_o,
  output logic [WORD_SIZE_P-1:0] sb_mem_data_o,
  input  logic                   mem_sb_ready_i,
  input  logic [WORD_SIZE_P-1:0] ld_addr_i,
  output logic                   sb_ld_hit_o,
  output logic [WORD_SIZE_P-1:0] sb_ld_data_o,
  output logic                   sb_empty_o
);
  localparam int PW = $clog2(SB_ENTRY);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(SB_ENTRY);

  logic [WORD_SIZE_P-1:0] r_addr [SB_ENTRY];
  logic [WORD_SIZE_P-1:0] r_data [SB_ENTRY];
  logic [SB_ENTRY-1:0]    r_valid;
  logic [SB_ENTRY-1:0]    r_cmt;
  logic [PW-1:0]          r_head;
  logic [PW-1:0]          r_cmt_pt;
  logic [PW-1:0]          r_tail;
  logic [CW-1:0]          r_num;
  logic [CW-1:0]          r_num_cmt;

  logic                   w_alloc;
  logic                   w_commit;
  logic                   w_mem_valid;
  logic                   w_drain;
  logic [PW-1:0]          w_idx [SB_ENTRY];
  logic [SB_ENTRY-1:0]    w_match;
  logic [WORD_SIZE_P-1:0] w_ld_data;

  // Space is judged on the registered count only, so a same-cycle drain never frees a slot early.
  assign sb_exe_ready_o = (r_num != FULL_C) & ~rob_mispredict_i;
  assign w_alloc        = exe_sb_valid_i & sb_exe_ready_o;
  assign w_commit       = rob_sb_valid_i & ~rob_mispredict_i & (r_num_cmt != r_num);
  assign w_mem_valid    = (r_num_cmt != {CW{1'b0}});
  assign w_drain        = w_mem_valid & mem_sb_ready_i;

  assign sb_mem_valid_o = w_mem_valid;
  assign sb_mem_addr_o  = w_mem_valid ? r_addr[r_head] : {WORD_SIZE_P{1'b0}};
  assign sb_mem_data_o  = w_mem_valid ? r_data[r_head] : {WORD_SIZE_P{1'b0}};
  assign sb_empty_o     = (r_num == {CW{1'b0}});

  // Pointer and occupancy bookkeeping; counters apply the net effect of alloc/commit/drain.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_head    <= {PW{1'b0}};
      r_cmt_pt  <= {PW{1'b0}};
      r_tail    <= {PW{1'b0}};
      r_num     <= {CW{1'b0}};
      r_num_cmt <= {CW{1'b0}};
    end else begin
      if (w_drain) begin
        r_head <= r_head + PW'(1);
      end
      if (w_commit) begin
        r_cmt_pt <= r_cmt_pt + PW'(1);
      end
      if (rob_mispredict_i) begin
        r_tail <= r_cmt_pt;
        r_num  <= r_num_cmt - CW'(w_drain);
      end else begin
        if (w_alloc) begin
          r_tail <= r_tail + PW'(1);
        end
        r_num <= r_num + CW'(w_alloc) - CW'(w_drain);
      end
      r_num_cmt <= r_num_cmt + CW'(w_commit) - CW'(w_drain);
    end
  end

  // Per-entry valid/committed flags; a flush drops only the uncommitted entries.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_valid <= {SB_ENTRY{1'b0}};
      r_cmt   <= {SB_ENTRY{1'b0}};
    end else begin
      for (int i = 0; i < SB_ENTRY; i++) begin
        if (rob_mispredict_i && !r_cmt[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
      if (w_drain) begin
        r_valid[r_head] <= 1'b0;
        r_cmt[r_head]   <= 1'b0;
      end
      if (w_commit) begin
        r_cmt[r_cmt_pt] <= 1'b1;
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_cmt[r_tail]   <= 1'b0;
      end
    end
  end

  // Address/data payload storage needs no reset; validity is tracked separately.
  always_ff @(posedge clk_i) begin
    if (w_alloc) begin
      r_addr[r_tail] <= exe_sb_addr_i;
      r_data[r_tail] <= exe_sb_data_i;
    end
  end

  for (genvar g = 0; g < SB_ENTRY; g++) begin : g_fwd
    assign w_idx[g]   = r_head + PW'(g);
    assign w_match[g] = r_valid[w_idx[g]] & (r_addr[w_idx[g]] == ld_addr_i);
  end

  // Walk oldest to youngest so the last matching entry (the youngest) wins.
  always_comb begin
    w_ld_data = {WORD_SIZE_P{1'b0}};
    for (int i = 0; i < SB_ENTRY; i++) begin
      w_ld_data = w_match[i] ? r_data[w_idx[i]] : w_ld_data;
    end
  end

  assign sb_ld_hit_o  = |w_match;
  assign sb_ld_data_o = w_ld_data;
endmodule

// File: tb/tb_store_buffer.sv
// Directed and randomized bench for store_buffer with a queue-based reference:
// committed stores are pushed when committed and popped when memory accepts them.
module tb_store_buffer;
  import common_pkg::*;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exe_valid = 1'b0;
  logic [31:0] exe_addr = 32'h0;
  logic [31:0] exe_data = 32'h0;
  logic        exe_ready;
  logic        rob_valid = 1'b0;
  logic        rob_mp = 1'b0;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_ready = 1'b0;
  logic [31:0] ld_addr = 32'h0;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        empty;

  int checks = 0;
  int errors = 0;
  int m_tail = 0;
  ent_t pend[$];
  ent_t cmtq[$];

  store_buffer #(.SB_ENTRY(8)) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .exe_sb_valid_i(exe_valid), .exe_sb_addr_i(exe_addr), .exe_sb_data_i(exe_data),
    .sb_exe_ready_o(exe_ready),
    .rob_sb_valid_i(rob_valid), .rob_mispredict_i(rob_mp),
    .sb_mem_valid_o(mem_valid), .sb_mem_addr_o(mem_addr), .sb_mem_data_o(mem_data),
    .mem_sb_ready_i(mem_ready),
    .ld_addr_i(ld_addr), .sb_ld_hit_o(ld_hit), .sb_ld_data_o(ld_data),
    .sb_empty_o(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(exe_ready), 32'd1);
    chk({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_data"}, mem_data, 32'd0);
    chk({tag, "_ld_hit"}, 32'(ld_hit), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs, advance the reference.
  task automatic step(input bit v, input logic [31:0] a, input logic [31:0] d,
                      input bit rc, input bit mp, input bit mr, input logic [31:0] la);
    bit          m_ready;
    bit          m_mv;
    bit          m_hit;
    logic [31:0] m_ld;
    int          n;
    @(negedge clk);
    exe_valid = v; exe_addr = a; exe_data = d;
    rob_valid = rc; rob_mp = mp; mem_ready = mr; ld_addr = la;
    #1;
    n       = pend.size() + cmtq.size();
    m_ready = (n != 8) && !mp;
    m_mv    = (cmtq.size() != 0);
    m_hit   = 1'b0;
    m_ld    = 32'h0;
    foreach (cmtq[k]) if (cmtq[k].a == la) begin m_hit = 1'b1; m_ld = cmtq[k].d; end
    foreach (pend[k]) if (pend[k].a == la) begin m_hit = 1'b1; m_ld = pend[k].d; end
    chk("ready", 32'(exe_ready), 32'(m_ready));
    chk("mem_valid", 32'(mem_valid), 32'(m_mv));
    if (m_mv) begin
      chk("mem_addr", mem_addr, cmtq[0].a);
      chk("mem_data", mem_data, cmtq[0].d);
    end
    chk("ld_hit", 32'(ld_hit), 32'(m_hit));
    chk("ld_data", ld_data, m_ld);
    chk("empty", 32'(empty), 32'(n == 0));
    chk("num", 32'(dut.r_num), 32'(n));
    chk("tail", 32'(dut.r_tail), 32'(m_tail));
    if (m_mv && mr) void'(cmtq.pop_front());
    if (mp) begin
      m_tail = (m_tail - pend.size() + 8) % 8;
      pend.delete();
    end else begin
      if (rc && pend.size() != 0) cmtq.push_back(pend.pop_front());
      if (v && m_ready) begin
        pend.push_back('{a, d});
        m_tail = (m_tail + 1) % 8;
      end
    end
  endtask

  task automatic idle(input bit mr);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, mr, 32'h0);
  endtask

  initial begin
    // Reset state, during and after reset.
    repeat (2) @(negedge clk);
    #1 chk_reset_outputs("rst_during");
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_reset_outputs("rst_after");

    // Two stores, one commit, single drain of the first.
    step(1'b1, 32'h10, 32'hAA, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h12, 32'hBB, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0);
    idle(1'b1);
    idle(1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    idle(1'b1);
    idle(1'b0);

    // Fill to capacity, extra store rejected, then commit+drain frees one slot.
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 32'h100 + 32'(i), 32'h200 + 32'(i), 1'b0, 1'b0, 1'b1, 32'h0);
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0);
    idle(1'b1);
    idle(1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    idle(1'b0);

    // Mispredict keeps the committed store and rewinds the tail.
    step(1'b1, 32'h10, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h14, 32'h2, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h18, 32'h3, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h99, 32'h9, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 32'h1C, 32'h4, 1'b0, 1'b0, 1'b1, 32'h0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    idle(1'b1);
    idle(1'b0);

    // Forwarding: youngest match, no match, and no same-cycle forward.
    step(1'b1, 32'h20, 32'h11, 1'b0, 1'b0, 1'b0, 32'h20);
    step(1'b1, 32'h20, 32'h22, 1'b0, 1'b0, 1'b0, 32'h20);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h20);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h30);
    step(1'b1, 32'h40, 32'h44, 1'b1, 1'b0, 1'b0, 32'h40);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h40);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h20);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h20);
    idle(1'b0);

    // Memory back-pressure with a mispredict in the middle.
    step(1'b1, 32'h50, 32'h55, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h60, 32'h66, 1'b1, 1'b0, 1'b0, 32'h0);
    idle(1'b0);
    idle(1'b0);
    step(1'b1, 32'h70, 32'h77, 1'b1, 1'b1, 1'b0, 32'h0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);

    // Randomized alloc/commit/drain traffic across pointer wrap.
    for (int i = 0; i < 20; i++) begin
      step(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom,
           1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2);
      chk("num_bound", 32'(dut.r_num <= 4'd8), 32'd1);
    end
    for (int i = 0; i < 40; i++) begin
      if (pend.size() + cmtq.size() != 0) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0);
    end
    idle(1'b0);

    // Reset asserted mid-drain drops everything.
    step(1'b1, 32'h80, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h84, 32'h9, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h80);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("rst_mid");
    pend.delete();
    cmtq.delete();
    m_tail = 0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h84);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter SB_ENTRY, default 8, entry count (power of 2, >=2).
REQ-002 SHALL use WORD_SIZE_P from the common package for address and data widths.
REQ-003 clk_i  in  1  sole clock; all state updates on posedge.
REQ-004 reset_n_i  in  1  asynchronous, active-low reset.
REQ-005 exe_sb_valid_i  in  1  execute presents a resolved store.
REQ-006 exe_sb_addr_i  in  WORD_SIZE_P  store address.
REQ-007 exe_sb_data_i  in  WORD_SIZE_P  store data.
REQ-008 sb_exe_ready_o  out  1  buffer can accept a store this cycle.
REQ-009 rob_sb_valid_i  in  1  ROB commit pulse: the oldest uncommitted store becomes committed.
REQ-010 rob_mispredict_i  in  1  ROB flush: discard all uncommitted stores.
REQ-011 sb_mem_valid_o  out  1  oldest committed store offered to memory.
REQ-012 sb_mem_addr_o / sb_mem_data_o  out  WORD_SIZE_P each  drained store address/data.
REQ-013 mem_sb_ready_i  in  1  memory accepts the offered store.
REQ-014 ld_addr_i  in  WORD_SIZE_P  load address for forwarding lookup.
REQ-015 sb_ld_hit_o  out  1  a buffered store matches ld_addr_i.
REQ-016 sb_ld_data_o  out  WORD_SIZE_P  data of youngest matching store.
REQ-017 sb_empty_o  out  1  no entries held.

Function
REQ-018 SHALL be a circular FIFO with three log2(SB_ENTRY)-bit pointers: head (oldest, drain), commit_pt (oldest uncommitted), tail (next alloc); all wrap SB_ENTRY-1 -> 0.
REQ-019 SHALL keep counters num (0..SB_ENTRY) and num_cmt (0..num), width log2(SB_ENTRY)+1.
REQ-020 sb_exe_ready_o SHALL equal (num != SB_ENTRY) & ~rob_mispredict_i, from registered num only (a same-cycle drain does not free space).
REQ-021 Alloc: exe_sb_valid_i & sb_exe_ready_o writes addr/data at tail, tail+1, num+1, entry uncommitted.
REQ-022 Commit: rob_sb_valid_i & ~rob_mispredict_i & (num_cmt != num) marks commit_pt entry committed, commit_pt+1, num_cmt+1; a commit with no uncommitted entry SHALL be ignored.
REQ-023 sb_mem_valid_o SHALL equal (num_cmt != 0); addr/data SHALL show the head entry; on valid & mem_sb_ready_i, head+1, num-1, num_cmt-1.
REQ-024 Alloc, commit and drain in one cycle SHALL all take effect; counters use net change.
REQ-025 A store committed in cycle N SHALL be offered to memory no earlier than cycle N+1.
REQ-026 Mispredict: tail <= commit_pt, num <= num_cmt; alloc and commit that cycle ignored; committed entries and a concurrent drain SHALL proceed unaffected.
REQ-027 sb_mem_valid_o SHALL not deassert, nor addr/data change, while valid & ~mem_sb_ready_i, including across a mispredict.
REQ-028 Forwarding is combinational over valid entries (committed or not), searching head to tail-1; sb_ld_data_o SHALL be the youngest match; a same-cycle alloc SHALL not forward.
REQ-029 With no match, sb_ld_hit_o=0 and sb_ld_data_o=0.
REQ-030 sb_empty_o SHALL equal (num == 0).

Reset
REQ-031 reset_n_i low SHALL asynchronously clear pointers, num, num_cmt and entry valid/commit bits; data storage need not be cleared.
REQ-032 During and after reset: sb_exe_ready_o=1, sb_mem_valid_o=0, sb_mem_addr_o=0, sb_mem_data_o=0, sb_ld_hit_o=0, sb_empty_o=1.
REQ-033 Reset asserted mid-drain SHALL drop all entries; no store is replayed after release.

Verification
REQ-034 Alloc 0x10/0xAA, 0x12/0xBB; commit one; mem_ready=1 -> one drain of 0x10/0xAA, then sb_mem_valid_o=0 with num=1.
REQ-035 Fill 8 stores, no commit -> sb_exe_ready_o=0; extra store ignored; drain not possible; commit+drain one -> ready=1 next cycle.
REQ-036 3 stores, commit 1, mispredict -> num=1, tail=commit_pt; committed 0x10 still drains; next alloc lands at former slot 1.
REQ-037 Stores 0x20/0x11 then 0x20/0x22, ld_addr_i=0x20 -> hit=1, data=0x22; ld_addr_i=0x30 -> hit=0, data=0.
REQ-038 mem_sb_ready_i=0 for 5 cycles with valid=1 and a mispredict -> addr/data stable, drains on ready.
REQ-039 Run 20 alloc/commit/drain cycles across wrap with random ready -> memory order equals commit order, num never exceeds 8.
